uart_tx_fifo: RTL and testbench

Byte queue and launch controller that sits directly upstream of the UART transmitter. It accepts bytes from the capture and readout logic through a valid/ready write port and buffers them in a power-of-two FIFO. It pops one byte at a time into the transmitter through its start/data/active/done interface, so producers never have to track serial timing.

---
 rtl/uart_pkg.sv | 12 +
 rtl/sync_fifo.sv | 77 +++++++
 rtl/uart_tx_fifo.sv | 100 ++++++++++
 tb/tb_uart_tx_fifo.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
//   tx_fifo_state_t : launch controller states
//   UART_BYTE_W     : width of one UART data byte
//   TX_FIFO_DEPTH   : default depth of the transmit byte queue
package uart_pkg;

    typedef enum logic [1:0] {IDLE, LAUNCH, BUSY, DRAIN} tx_fifo_state_t;

    localparam int UART_BYTE_W   = 8;
    localparam int TX_FIFO_DEPTH = 16;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count and synchronous flush.
//   clk, rst_n    : clock, asynchronous active-low reset
//   flush         : drop all entries on the next edge (wins over push/pop)
//   push, wdata   : write request; ignored while full
//   pop           : advance read pointer; ignored while empty
//   rdata         : head entry (combinational read)
//   level         : number of stored entries, 0..DEPTH
//   full, empty   : derived from level
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8,
    parameter int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [LVL_W-1:0] level,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = LVL_W - 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             do_push, do_pop;

    assign full    = (level_q == LVL_W'(DEPTH));
    assign empty   = (level_q == '0);
    assign do_push = push & ~full & ~flush;
    assign do_pop  = pop & ~empty & ~flush;
    assign rdata   = mem_q[rptr_q];
    assign level   = level_q;

    // Pointers wrap naturally since DEPTH is a power of two.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            level_d = '0;
        end else begin
            if (do_push) wptr_d = wptr_q + PTR_W'(1);
            if (do_pop)  rptr_d = rptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   level_d = level_q + LVL_W'(1);
                2'b01:   level_d = level_q - LVL_W'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
        end
    end

    // Storage needs no reset: contents are only visible through level.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= wdata;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte queue and launch controller feeding the UART transmitter.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_data    : producer write port, accepted when in_ready
//   in_ready            : FIFO not full (registered state only)
//   flush               : discard all queued bytes
//   clr_ovf             : clear the sticky overflow flag
//   tx_start/tx_data    : one-cycle launch pulse and byte to send
//   tx_active/tx_done   : transmitter busy / completion flag
//   level               : queued byte count
//   overflow            : sticky, write attempted while full
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = TX_FIFO_DEPTH,
    parameter int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic [UART_BYTE_W-1:0] in_data,
    output logic                   in_ready,
    input  logic                   flush,
    input  logic                   clr_ovf,
    output logic                   tx_start,
    output logic [UART_BYTE_W-1:0] tx_data,
    input  logic                   tx_active,
    input  logic                   tx_done,
    output logic [LVL_W-1:0]       level,
    output logic                   overflow
);

    tx_fifo_state_t         state_q, state_d;
    logic [UART_BYTE_W-1:0] tx_data_q, tx_data_d;
    logic                   ovf_q, ovf_d;
    logic [UART_BYTE_W-1:0] head;
    logic                   full, empty, pop;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (UART_BYTE_W),
        .LVL_W (LVL_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .push  (in_valid),
        .wdata (in_data),
        .pop   (pop),
        .rdata (head),
        .level (level),
        .full  (full),
        .empty (empty)
    );

    assign in_ready = ~full;
    assign tx_start = (state_q == LAUNCH);
    assign tx_data  = tx_data_q;
    assign overflow = ovf_q;

    // The transmitter is not reset with us, so a launch also waits for any
    // byte it is still finishing (tx_active) or signalling (tx_done).
    always_comb begin
        state_d   = state_q;
        tx_data_d = tx_data_q;
        pop       = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty && !tx_active && !tx_done && !flush) begin
                    state_d   = LAUNCH;
                    tx_data_d = head;
                    pop       = 1'b1;
                end
            end
            LAUNCH:  state_d = BUSY;
            BUSY:    if (tx_done)  state_d = DRAIN;
            DRAIN:   if (!tx_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Setting has priority over clearing so no overflow event is lost.
    always_comb begin
        ovf_d = ovf_q;
        if (in_valid && full) ovf_d = 1'b1;
        else if (clr_ovf)     ovf_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            tx_data_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_data_q <= tx_data_d;
            ovf_q     <= ovf_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;

    localparam int DEPTH = 16;
    localparam int LVL_W = 5;
    localparam int CPB   = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid, flush, clr_ovf;
    logic [7:0]       in_data;
    logic             in_ready, tx_start, overflow;
    logic [7:0]       tx_data;
    logic             tx_active, tx_done;
    logic [LVL_W-1:0] level;

    always #5 clk = ~clk;

    uart_tx_fifo #(.DEPTH(DEPTH), .LVL_W(LVL_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .flush(flush), .clr_ovf(clr_ovf),
        .tx_start(tx_start), .tx_data(tx_data), .tx_active(tx_active),
        .tx_done(tx_done), .level(level), .overflow(overflow)
    );

    // Transmitter model: no reset, 8N1 framing, done held for 2 cycles.
    logic       m_active = 1'b0;
    int         m_cnt = 0, m_bits = 0, m_done = 0;
    logic [9:0] m_sh = '1, m_cap = '0;
    logic       ser;
    logic       hold_busy = 1'b0;
    logic [9:0] frame_q[$];

    assign ser       = m_active ? m_sh[0] : 1'b1;
    assign tx_active = m_active | hold_busy;
    assign tx_done   = (m_done != 0);

    always @(posedge clk) begin
        if (tx_start && !m_active) begin
            m_active <= 1'b1;
            m_sh     <= {1'b1, tx_data, 1'b0};
            m_bits   <= 0;
            m_cnt    <= 0;
        end else if (m_active) begin
            if (m_cnt == CPB / 2) m_cap[m_bits] <= ser;
            if (m_cnt == CPB - 1) begin
                m_cnt  <= 0;
                m_sh   <= {1'b1, m_sh[9:1]};
                m_bits <= m_bits + 1;
                if (m_bits == 9) begin
                    m_active <= 1'b0;
                    m_done   <= 2;
                    frame_q.push_back(m_cap);
                end
            end else begin
                m_cnt <= m_cnt + 1;
            end
        end else if (m_done > 0) begin
            m_done <= m_done - 1;
        end
    end

    // Reference: bytes queued but not yet launched, and the sticky flag.
    logic [7:0] ref_q[$];
    logic [7:0] launched_q[$];
    logic       ref_ovf = 1'b0;
    logic       prev_start = 1'b0, prev_done = 1'b0;
    int         n_start = 0, n_done = 0, peak = 0;
    int         tests = 0, fails = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic v, input logic [7:0] d, input logic fl, input logic clr);
        int         sz;
        logic       acc, ovs;
        logic [9:0] f;
        in_valid = v; in_data = d; flush = fl; clr_ovf = clr;
        sz  = ref_q.size();
        acc = v && (sz < DEPTH);
        ovs = v && (sz == DEPTH);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0; clr_ovf = 1'b0;
        if (fl) ref_q.delete();
        else if (acc) ref_q.push_back(d);
        if (ovs) ref_ovf = 1'b1;
        else if (clr) ref_ovf = 1'b0;
        if (tx_start) begin
            n_start++;
            chk("start_spacing", 32'(prev_start | tx_active | tx_done), 32'd0);
            if (ref_q.size() == 0) chk("start_when_empty", 32'(tx_start), 32'd0);
            else chk("tx_data", 32'(tx_data), 32'(ref_q.pop_front()));
            launched_q.push_back(tx_data);
        end
        if (tx_done && !prev_done) n_done++;
        prev_done  = tx_done;
        prev_start = tx_start;
        if (ref_q.size() > peak) peak = ref_q.size();
        chk("level", 32'(level), 32'(ref_q.size()));
        chk("in_ready", 32'(in_ready), 32'(ref_q.size() < DEPTH));
        chk("overflow", 32'(overflow), 32'(ref_ovf));
        if (frame_q.size() > 0) begin
            f = frame_q.pop_front();
            chk("frame_start_bit", 32'(f[0]), 32'd0);
            chk("frame_stop_bit", 32'(f[9]), 32'd1);
            if (launched_q.size() == 0) chk("frame_unlaunched", 32'(f[8:1]), 32'hFFFF);
            else chk("frame_data", 32'(f[8:1]), 32'(launched_q.pop_front()));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic wait_drain();
        int k;
        k = 0;
        while ((ref_q.size() != 0 || m_active || m_done != 0 || frame_q.size() != 0 ||
                launched_q.size() != 0) && k < 3000) begin
            step(1'b0, 8'h00, 1'b0, 1'b0);
            k++;
        end
        step(1'b0, 8'h00, 1'b0, 1'b0);
        if (k >= 3000) chk("drain_timeout", 32'(k), 32'd0);
    endtask

    task automatic wait_start();
        int k;
        k = 0;
        while (!tx_start && k < 200) begin
            step(1'b0, 8'h00, 1'b0, 1'b0);
            k++;
        end
        if (k >= 200) chk("start_timeout", 32'(k), 32'd0);
    endtask

    task automatic chk_reset_vals();
        chk("rst_tx_start", 32'(tx_start), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_overflow", 32'(overflow), 32'd0);
    endtask

    initial begin
        int s0, d0;
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; flush = 1'b0; clr_ovf = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_vals();
        rst_n = 1'b1;

        // Single byte: launch two clocks after the push.
        s0 = n_start;
        step(1'b1, 8'hA5, 1'b0, 1'b0);
        chk("lat_no_start_yet", 32'(tx_start), 32'd0);
        chk("lat_level_1", 32'(level), 32'd1);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("lat_start", 32'(tx_start), 32'd1);
        chk("lat_data", 32'(tx_data), 32'hA5);
        wait_drain();
        chk("a5_one_start", 32'(n_start - s0), 32'd1);

        // 16 back-to-back pushes: one pops early, peak 15.
        peak = 0;
        for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        chk("burst_peak", 32'(peak), 32'd15);
        chk("burst_no_ovf", 32'(overflow), 32'd0);
        wait_drain();
        chk("burst_level_end", 32'(level), 32'd0);

        // Fill while transmitter held busy, then overflow and clear.
        hold_busy = 1'b1;
        for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        step(1'b1, 8'hFF, 1'b0, 1'b0);
        chk("ovf_set", 32'(overflow), 32'd1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("ovf_clr", 32'(overflow), 32'd0);
        step(1'b1, 8'hFF, 1'b0, 1'b1);
        chk("ovf_set_wins", 32'(overflow), 32'd1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        hold_busy = 1'b0;
        wait_drain();

        // Push and pop on the same edge at level 5.
        hold_busy = 1'b1;
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h50 + i), 1'b0, 1'b0);
        hold_busy = 1'b0;
        step(1'b1, 8'h77, 1'b0, 1'b0);
        chk("pushpop_level", 32'(level), 32'd5);
        wait_drain();

        // Flush during BUSY with 6 left queued.
        hold_busy = 1'b1;
        for (int i = 0; i < 7; i++) step(1'b1, 8'(8'h90 + i), 1'b0, 1'b0);
        hold_busy = 1'b0;
        wait_start();
        chk("flush_pre_level", 32'(level), 32'd6);
        idle(3);
        s0 = n_start; d0 = n_done;
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("flush_level", 32'(level), 32'd0);
        wait_drain();
        chk("flush_no_start", 32'(n_start - s0), 32'd0);
        chk("flush_one_done", 32'(n_done - d0), 32'd1);

        // Reset mid-byte while the transmitter keeps going.
        step(1'b1, 8'h5A, 1'b0, 1'b0);
        wait_start();
        idle(10);
        rst_n = 1'b0;
        #1;
        chk_reset_vals();
        @(negedge clk);
        rst_n = 1'b1;
        ref_q.delete(); ref_ovf = 1'b0; prev_start = 1'b0;
        s0 = n_start;
        step(1'b1, 8'h3C, 1'b0, 1'b0);
        wait_drain();
        chk("rst_3c_one_start", 32'(n_start - s0), 32'd1);

        // Randomised traffic with occasional flush and clear.
        for (int i = 0; i < 600; i++)
            step(1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 31) == 0),
                 ($urandom_range(0, 15) == 0));
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
